// File: rtl/rkold_vector_buffer.sv
// Multi-lane row buffer with per-lane masked writes, registered reads and a row-per-cycle zero-fill.
// Define RKOLD_VECTOR_BUFFER_BYPASS_EN to forward same-row write data to a concurrent read.
module rkold_vector_buffer #(
   parameter int ELEMENT_WIDTH          = 64,
   parameter int NO_OF_UNITS            = 8,
   parameter int DEPTH                  = 1024,
   parameter int MEMORIES_ADDRESS_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  wr_en,
   input  logic [MEMORIES_ADDRESS_WIDTH-1:0]     wr_addr,
   input  logic [NO_OF_UNITS-1:0]                wr_lane_mask,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  wr_data,
   input  logic                                  rd_en,
   input  logic [MEMORIES_ADDRESS_WIDTH-1:0]     rd_addr,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  rd_data,
   output logic                                  rd_valid,
   input  logic                                  clear_start,
   output logic                                  clear_busy,
   output logic                                  addr_error
);

   localparam int ROW_W = ELEMENT_WIDTH * NO_OF_UNITS;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW    = MEMORIES_ADDRESS_WIDTH;
   localparam logic [AW:0]      DEPTH_X  = (AW+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_cnt;
   logic [ROW_W-1:0]  mem [DEPTH];

   logic              idle_ok;
   logic              wr_oor;
   logic              rd_oor;
   logic              do_wr;
   logic              do_rd;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [ROW_W-1:0]  rd_row;

   // An accepted clear_start blocks same-cycle reads and writes.
   assign idle_ok = (state == IDLE) && !clear_start;
   assign wr_oor  = {1'b0, wr_addr} >= DEPTH_X;
   assign rd_oor  = {1'b0, rd_addr} >= DEPTH_X;
   assign do_wr   = idle_ok && wr_en && !wr_oor;
   assign do_rd   = idle_ok && rd_en;
   assign wr_idx  = wr_addr[IDX_W-1:0];
   assign rd_idx  = rd_addr[IDX_W-1:0];

   always_comb begin
      rd_row = mem[rd_idx];
`ifdef RKOLD_VECTOR_BUFFER_BYPASS_EN
      if (do_wr && !rd_oor && (wr_idx == rd_idx)) begin
         for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
            if (wr_lane_mask[i])
               rd_row[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = wr_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         addr_error <= 1'b0;
         clear_busy <= 1'b0;
      end else begin
         rd_valid   <= do_rd;
         addr_error <= idle_ok && ((rd_en && rd_oor) || (wr_en && wr_oor));
         if (do_rd)
            rd_data <= rd_oor ? '0 : rd_row;
         case (state)
            IDLE: begin
               if (clear_start) begin
                  state      <= CLEAR;
                  clr_cnt    <= '0;
                  clear_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_cnt == LAST_ROW) begin
                  state      <= IDLE;
                  clr_cnt    <= '0;
                  clear_busy <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is never reset; rst_n only gates updates so a reset mid-fill leaves rows partly cleared.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
         end else if (do_wr) begin
            for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
               if (wr_lane_mask[i])
                  mem[wr_idx][i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= wr_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end
         end
      end
   end

endmodule

// File: tb/tb_rkold_vector_buffer.sv
// Directed table-driven bench for rkold_vector_buffer (8 lanes x 8 bits, 32 rows).
module tb_rkold_vector_buffer;

   localparam int EW = 8;
   localparam int NU = 8;
   localparam int DP = 32;
   localparam int AW = 32;
   localparam int RW = EW * NU;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [NU-1:0] wr_lane_mask = '0;
   logic [RW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [RW-1:0] rd_data;
   logic          rd_valid;
   logic          clear_start = 1'b0;
   logic          clear_busy;
   logic          addr_error;

   int passed = 0;
   int total  = 0;

   rkold_vector_buffer #(
      .ELEMENT_WIDTH(EW),
      .NO_OF_UNITS(NU),
      .DEPTH(DP),
      .MEMORIES_ADDRESS_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .clear_start(clear_start), .clear_busy(clear_busy), .addr_error(addr_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [NU-1:0] wm;
      logic [RW-1:0] wd;
      logic          re;
      logic [AW-1:0] ra;
      logic          ev;
      logic [RW-1:0] ed;
      logic          ee;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
      wr_lane_mask = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
   endtask

   initial begin
      logic [RW-1:0] coll;
      int n;
      logic bad;
`ifdef RKOLD_VECTOR_BUFFER_BYPASS_EN
      coll = 64'hF1F2F3F4_05060708;
`else
      coll = 64'h01020304_05060708;
`endif
      //           we    wa     wm     wd                     re    ra           ev    ed                     ee
      vecs[0]  = '{1'b1, 32'd0, 8'hFF, 64'h5A5A5A5A5A5A5A5A, 1'b0, 32'd0,       1'b0, 64'h0,                 1'b0};
      vecs[1]  = '{1'b1, 32'd5, 8'hFF, 64'h8877665544332211, 1'b0, 32'd0,       1'b0, 64'h0,                 1'b0};
      vecs[2]  = '{1'b0, 32'd0, 8'h00, 64'h0,                1'b1, 32'd5,       1'b1, 64'h8877665544332211, 1'b0};
      vecs[3]  = '{1'b1, 32'd5, 8'h01, 64'hAAAAAAAAAAAAAAFF, 1'b0, 32'd0,       1'b0, 64'h8877665544332211, 1'b0};
      vecs[4]  = '{1'b0, 32'd0, 8'h00, 64'h0,                1'b1, 32'd5,       1'b1, 64'h88776655443322FF, 1'b0};
      vecs[5]  = '{1'b1, 32'd3, 8'hFF, 64'h0102030405060708, 1'b0, 32'd0,       1'b0, 64'h88776655443322FF, 1'b0};
      vecs[6]  = '{1'b1, 32'd3, 8'hF0, 64'hF1F2F3F4F5F6F7F8, 1'b1, 32'd3,       1'b1, coll,                  1'b0};
      vecs[7]  = '{1'b0, 32'd0, 8'h00, 64'h0,                1'b1, 32'd3,       1'b1, 64'hF1F2F3F405060708, 1'b0};
      vecs[8]  = '{1'b0, 32'd0, 8'h00, 64'h0,                1'b1, 32'd32,      1'b1, 64'h0,                 1'b1};
      vecs[9]  = '{1'b1, 32'd32, 8'hFF, 64'h0,               1'b0, 32'd0,       1'b0, 64'h0,                 1'b1};
      vecs[10] = '{1'b0, 32'd0, 8'h00, 64'h0,                1'b1, 32'd0,       1'b1, 64'h5A5A5A5A5A5A5A5A, 1'b0};
      vecs[11] = '{1'b0, 32'd0, 8'h00, 64'h0,                1'b0, 32'd0,       1'b0, 64'h5A5A5A5A5A5A5A5A, 1'b0};
      vecs[12] = '{1'b1, 32'd32, 8'hFF, 64'h0,               1'b1, 32'hFFFFFFFF, 1'b1, 64'h0,                 1'b1};
      vecs[13] = '{1'b1, 32'd7, 8'hFF, 64'h7777777777777777, 1'b1, 32'd5,       1'b1, 64'h88776655443322FF, 1'b0};
      vecs[14] = '{1'b0, 32'd0, 8'h00, 64'h0,                1'b1, 32'd7,       1'b1, 64'h7777777777777777, 1'b0};
      vecs[15] = '{1'b1, 32'd20, 8'hFF, 64'h2020202020202020, 1'b0, 32'd0,      1'b0, 64'h7777777777777777, 1'b0};

      // Reset held across two edges.
      idle_in();
      tick(); tick();
      chk("reset rd_data",    rd_data, '0);
      chk("reset rd_valid",   RW'(rd_valid), '0);
      chk("reset addr_error", RW'(addr_error), '0);
      chk("reset clear_busy", RW'(clear_busy), '0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_lane_mask = vecs[i].wm; wr_data = vecs[i].wd;
         rd_en = vecs[i].re; rd_addr = vecs[i].ra;
         tick();
         chk($sformatf("vec%0d rd_valid", i),   RW'(rd_valid),   RW'(vecs[i].ev));
         chk($sformatf("vec%0d rd_data", i),    rd_data,         vecs[i].ed);
         chk($sformatf("vec%0d addr_error", i), RW'(addr_error), RW'(vecs[i].ee));
      end

      // Zero-fill: clear_start together with read/write, both must be blocked.
      idle_in();
      clear_start = 1'b1;
      rd_en = 1'b1; rd_addr = 32'd5;
      wr_en = 1'b1; wr_addr = 32'd5; wr_lane_mask = 8'hFF; wr_data = '1;
      tick();
      clear_start = 1'b0;
      chk("clear start busy",  RW'(clear_busy), RW'(1'b1));
      chk("clear start rd_valid", RW'(rd_valid), '0);
      rd_addr = 32'd32;
      n = 0; bad = 1'b0;
      while (clear_busy && n < 2*DP) begin
         n++;
         if (rd_valid || addr_error) bad = 1'b1;
         clear_start = (n == 5);
         tick();
      end
      idle_in();
      chk("clear busy cycles", RW'(n), RW'(DP));
      chk("clear rd ignored",  RW'(bad), '0);
      rd_en = 1'b1; rd_addr = 32'd5;
      tick();
      chk("clear row5 valid", RW'(rd_valid), RW'(1'b1));
      chk("clear row5 data",  rd_data, '0);
      rd_addr = 32'd20;
      tick();
      chk("clear row20 data", rd_data, '0);

      // Reset partway through a clear.
      idle_in();
      wr_en = 1'b1; wr_addr = 32'd20; wr_lane_mask = 8'hFF; wr_data = 64'h2020202020202020;
      tick();
      idle_in();
      rd_en = 1'b1; rd_addr = 32'd20;
      tick();
      chk("pre-clear row20", rd_data, 64'h2020202020202020);
      idle_in();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("mid clear busy", RW'(clear_busy), RW'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("abort rd_data",    rd_data, '0);
      chk("abort clear_busy", RW'(clear_busy), '0);
      chk("abort rd_valid",   RW'(rd_valid), '0);
      chk("abort addr_error", RW'(addr_error), '0);
      tick();
      rst_n = 1'b1;
      rd_en = 1'b1; rd_addr = 32'd20;
      tick();
      chk("abort row20 valid", RW'(rd_valid), RW'(1'b1));
      chk("abort row20 kept",  rd_data, 64'h2020202020202020);
      rd_addr = 32'd0;
      tick();
      chk("abort row0 cleared", rd_data, '0);
      idle_in();
      tick();
      chk("abort busy after", RW'(clear_busy), '0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rkold_vector_buffer.md
RKOLD_VECTOR_BUFFER -- requirements
Module: rkold_vector_buffer

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 64, bits per element.
REQ-002 SHALL have parameter NO_OF_UNITS, default 8, elements (lanes) per row.
REQ-003 SHALL have parameter DEPTH, default 1024, number of rows.
REQ-004 SHALL have parameter MEMORIES_ADDRESS_WIDTH, default 32, address port width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_addr, input, MEMORIES_ADDRESS_WIDTH, write row.
REQ-009 SHALL have port wr_lane_mask, input, NO_OF_UNITS, per-lane write enable; bit i covers element i.
REQ-010 SHALL have port wr_data, input, ELEMENT_WIDTH*NO_OF_UNITS, row data; element i at bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].
REQ-011 SHALL have port rd_en, input, 1, read request.
REQ-012 SHALL have port rd_addr, input, MEMORIES_ADDRESS_WIDTH, read row.
REQ-013 SHALL have port rd_data, output, ELEMENT_WIDTH*NO_OF_UNITS, registered read data.
REQ-014 SHALL have port rd_valid, output, 1, rd_data valid for that cycle.
REQ-015 SHALL have port clear_start, input, 1, one-cycle pulse starting a zero-fill of all rows.
REQ-016 SHALL have port clear_busy, output, 1, high while the zero-fill runs.
REQ-017 SHALL have port addr_error, output, 1, one-cycle pulse for an out-of-range access.

Function
REQ-018 SHALL write lane i of row wr_addr on the clk edge when wr_en=1, wr_mask bit i=1, FSM in IDLE and wr_addr<DEPTH; unmasked lanes keep their contents.
REQ-019 SHALL register the read: rd_en=1 in cycle N gives rd_data and rd_valid=1 in cycle N+1; rd_en=0 gives rd_valid=0 with rd_data held.
REQ-020 SHALL return all-zero rd_data with rd_valid=1 and addr_error=1 for a read with rd_addr>=DEPTH.
REQ-021 SHALL drop a write with wr_addr>=DEPTH and pulse addr_error=1 in the following cycle.
REQ-022 SHALL pulse addr_error for one cycle when either port or both are out of range in the same cycle.
REQ-023 SHALL use FSM states IDLE and CLEAR: IDLE->CLEAR on clear_start; CLEAR->IDLE after row DEPTH-1 is written.
REQ-024 SHALL, in CLEAR, zero one full row per cycle from row 0 up to row DEPTH-1, taking DEPTH cycles, with clear_busy=1 throughout.
REQ-025 SHALL ignore wr_en and rd_en while in CLEAR (rd_valid=0, no writes, no addr_error).
REQ-026 SHALL ignore clear_start while in CLEAR; an accepted clear_start also blocks any same-cycle wr_en and rd_en.
REQ-027 SHALL resolve a same-cycle read and write to the same in-range row according to REQ-031/REQ-032.

Reset
REQ-028 SHALL, on rst_n=0, immediately force rd_data=0, rd_valid=0, addr_error=0, clear_busy=0, FSM=IDLE and clear row counter=0.
REQ-029 SHALL NOT reset memory contents; reset during CLEAR aborts the fill and leaves rows partly cleared.
REQ-030 SHALL take the first request on the first rising edge after rst_n goes high.

Configuration
REQ-031 SHALL, with RKOLD_VECTOR_BUFFER_BYPASS_EN defined, forward on a same-row read/write collision: rd_data lane i = wr_data lane i where mask bit i=1, otherwise the stored lane.
REQ-032 SHALL, without RKOLD_VECTOR_BUFFER_BYPASS_EN, return the pre-write (old) row contents on a same-row collision.

Verification
REQ-033 SHALL check: write row 5 all lanes 0x11..0x88, then read row 5 -> next cycle rd_valid=1, rd_data = written row.
REQ-034 SHALL check: write row 5 with mask 8'h01, lane 0 = 0xFF -> lane 0 = 0xFF, lanes 1-7 unchanged.
REQ-035 SHALL check: read rd_addr=DEPTH -> rd_valid=1, rd_data=0, addr_error=1; write wr_addr=DEPTH -> no row changes, addr_error=1.
REQ-036 SHALL check: clear_start -> clear_busy high for exactly DEPTH cycles, rd_en ignored meanwhile, then any row reads 0.
REQ-037 SHALL check: same-cycle write and read of row 3 with mask 8'hF0 -> upper 4 lanes new with bypass macro, all lanes old without.
REQ-038 SHALL check: rst_n low at clear cycle 10 -> outputs 0 at once, clear_busy=0, row 20 keeps its pre-clear data.
